// File: rtl/multiplexer_arbiter.sv
// Round-robin arbiter sharing one N:1 multiplexer between N requesters
// (N = 2**NUM_OF_CONTROL_SIGNALS). The current owner keeps the grant until it
// drops its request. An optional hold limit can force the grant to move.
//
// Ports:
//   clk              clock; all state changes on the rising edge
//   reset            synchronous, active-high reset
//   request[N]       request[i] high = requester i wants or keeps the mux
//   grant[N]         one-hot owner; all-zero when idle
//   grant_valid      high while some requester owns the mux
//   control_signals  owner index, drives the multiplexer select
//   preempted        1-cycle pulse when the hold limit removed a grant
module multiplexer_arbiter #(
  parameter int unsigned NUM_OF_CONTROL_SIGNALS = 1,
  parameter int unsigned MAX_HOLD_CYCLES        = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [2**NUM_OF_CONTROL_SIGNALS-1:0] request,
  output logic [2**NUM_OF_CONTROL_SIGNALS-1:0] grant,
  output logic                              grant_valid,
  output logic [NUM_OF_CONTROL_SIGNALS-1:0] control_signals,
  output logic                              preempted
);

  localparam int unsigned W       = NUM_OF_CONTROL_SIGNALS;
  localparam int unsigned N       = 2 ** W;
  localparam bit          Limited = (MAX_HOLD_CYCLES > 0);
  localparam int unsigned HoldW   = Limited ? $clog2(MAX_HOLD_CYCLES + 1) : 1;
  localparam int unsigned HoldLast = Limited ? MAX_HOLD_CYCLES - 1 : 0;
  localparam logic [HoldW-1:0] HoldLastV = HoldW'(HoldLast);
  localparam logic [HoldW-1:0] HoldMaxV  = HoldW'(MAX_HOLD_CYCLES);

  typedef enum logic [0:0] {StIdle, StOwned} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [W-1:0]     ctrl_q, ctrl_d;
  logic [W-1:0]     last_q, last_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             pre_q, pre_d;

  logic [N-1:0]     scan_req;
  logic             pick_found;
  logic [W-1:0]     pick_idx;
  logic             limit_hit;

  // First set request scanning last+1, last+2, ... wrapping to last.
  // Index arithmetic wraps naturally because N is a power of two.
  function automatic logic [W:0] rr_pick(input logic [N-1:0] req, input logic [W-1:0] last);
    logic [W:0]   res;
    logic [W-1:0] cand;
    res = '0;
    for (int i = 1; i <= int'(N); i++) begin
      cand = last + W'(i);
      if (!res[W] && req[cand]) begin
        res = {1'b1, cand};
      end
    end
    return res;
  endfunction

  // The owner is masked out of the scan, so a preempted owner cannot win again
  // in the same cycle. On release its bit is already low; in idle grant_q is 0.
  assign scan_req = request & ~grant_q;
  assign {pick_found, pick_idx} = rr_pick(scan_req, last_q);

  // hold_q counts owned cycles already completed; this edge completes one more.
  assign limit_hit = Limited && (hold_q >= HoldLastV);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ctrl_d  = ctrl_q;
    last_d  = last_q;
    hold_d  = hold_q;
    pre_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d = StOwned;
          grant_d = N'(1) << pick_idx;
          ctrl_d  = pick_idx;
          last_d  = pick_idx;
          hold_d  = '0;
        end
      end
      StOwned: begin
        if (!request[ctrl_q]) begin
          // Release wins over the hold limit, so preempted stays low here.
          if (pick_found) begin
            grant_d = N'(1) << pick_idx;
            ctrl_d  = pick_idx;
            last_d  = pick_idx;
          end else begin
            state_d = StIdle;
            grant_d = '0;
          end
          hold_d = '0;
        end else if (limit_hit && pick_found) begin
          grant_d = N'(1) << pick_idx;
          ctrl_d  = pick_idx;
          last_d  = pick_idx;
          hold_d  = '0;
          pre_d   = 1'b1;
        end else if (Limited && (hold_q != HoldMaxV)) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      ctrl_q  <= '0;
      last_q  <= {W{1'b1}};
      hold_q  <= '0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ctrl_q  <= ctrl_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      pre_q   <= pre_d;
    end
  end

  assign grant           = grant_q;
  assign grant_valid     = (state_q == StOwned);
  assign control_signals = ctrl_q;
  assign preempted       = pre_q;

endmodule

// File: tb/tb_multiplexer_arbiter.sv
module tb_multiplexer_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] request;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] control_signals;
  logic       preempted;

  int vectors = 0;
  int miscompares = 0;

  multiplexer_arbiter #(
    .NUM_OF_CONTROL_SIGNALS(2),
    .MAX_HOLD_CYCLES       (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .request        (request),
    .grant          (grant),
    .grant_valid    (grant_valid),
    .control_signals(control_signals),
    .preempted      (preempted)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then move 1 time unit away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] eg, input logic ev,
                     input logic [1:0] ec, input logic ep);
    vectors++;
    assert ({grant, grant_valid, control_signals, preempted} === {eg, ev, ec, ep})
    else begin
      miscompares++;
      $error("FAIL %s: observed grant=%b valid=%b ctrl=%0d pre=%b, expected grant=%b valid=%b ctrl=%0d pre=%b",
             tag, grant, grant_valid, control_signals, preempted, eg, ev, ec, ep);
    end
  endtask

  initial begin
    // Reset held with all requests set, then first grant goes to requester 0.
    reset = 1'b1; request = 4'b1111;
    step(); chk("reset_c0", 4'b0000, 1'b0, 2'd0, 1'b0);
    step(); chk("reset_c1", 4'b0000, 1'b0, 2'd0, 1'b0);
    reset = 1'b0;
    step(); chk("first_grant", 4'b0001, 1'b1, 2'd0, 1'b0);

    // Each owner releases after one cycle: 0,1,2,3,0 with no idle bubble.
    request = 4'b1110; step(); chk("rr_1", 4'b0010, 1'b1, 2'd1, 1'b0);
    request = 4'b1101; step(); chk("rr_2", 4'b0100, 1'b1, 2'd2, 1'b0);
    request = 4'b1011; step(); chk("rr_3", 4'b1000, 1'b1, 2'd3, 1'b0);
    request = 4'b0111; step(); chk("rr_0", 4'b0001, 1'b1, 2'd0, 1'b0);

    // Single requester 2, then drop: idle with select held.
    reset = 1'b1; request = 4'b0000; step();
    reset = 1'b0; request = 4'b0100;
    step(); chk("single_grant", 4'b0100, 1'b1, 2'd2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(); chk("single_hold", 4'b0100, 1'b1, 2'd2, 1'b0);
    end
    request = 4'b0000;
    step(); chk("single_drop", 4'b0000, 1'b0, 2'd2, 1'b0);
    step(); chk("idle_stays", 4'b0000, 1'b0, 2'd2, 1'b0);

    // Hold limit: req0 owns 4 cycles, then req2 preempts, then req0 returns.
    reset = 1'b1; step();
    reset = 1'b0; request = 4'b0001;
    step(); chk("hold_c1", 4'b0001, 1'b1, 2'd0, 1'b0);
    request = 4'b0101;
    step(); chk("hold_c2", 4'b0001, 1'b1, 2'd0, 1'b0);
    step(); chk("hold_c3", 4'b0001, 1'b1, 2'd0, 1'b0);
    step(); chk("hold_c4", 4'b0001, 1'b1, 2'd0, 1'b0);
    step(); chk("preempt", 4'b0100, 1'b1, 2'd2, 1'b1);
    step(); chk("preempt_pulse_end", 4'b0100, 1'b1, 2'd2, 1'b0);
    request = 4'b0001;
    step(); chk("regrant_0", 4'b0001, 1'b1, 2'd0, 1'b0);

    // Sole requester never preempted; counter saturates.
    reset = 1'b1; step();
    reset = 1'b0; request = 4'b0010;
    step(); chk("sole_c1", 4'b0010, 1'b1, 2'd1, 1'b0);
    for (int i = 0; i < 19; i++) begin
      step(); chk("sole_hold", 4'b0010, 1'b1, 2'd1, 1'b0);
    end

    // Owner drop coincides with hold limit: plain release, no preempt pulse.
    reset = 1'b1; step();
    reset = 1'b0; request = 4'b0001;
    step(); chk("drop_lim_c1", 4'b0001, 1'b1, 2'd0, 1'b0);
    request = 4'b0011;
    step(); step(); step(); chk("drop_lim_c4", 4'b0001, 1'b1, 2'd0, 1'b0);
    request = 4'b0010;
    step(); chk("drop_lim_move", 4'b0010, 1'b1, 2'd1, 1'b0);

    // Reset mid-ownership of req3, then req0 wins first.
    reset = 1'b1; step();
    reset = 1'b0; request = 4'b1000;
    step(); chk("own3", 4'b1000, 1'b1, 2'd3, 1'b0);
    step(); chk("own3_hold", 4'b1000, 1'b1, 2'd3, 1'b0);
    reset = 1'b1; request = 4'b1001;
    step(); chk("mid_reset", 4'b0000, 1'b0, 2'd0, 1'b0);
    reset = 1'b0;
    step(); chk("after_reset", 4'b0001, 1'b1, 2'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
